// File: rtl/lcd_hd44780_responder.sv
// LCD-side HD44780 4-wire bus responder: decodes host strobes and emulates the busy flag and address counter.
// Define LCD_RESPONDER_DDRAM_EN to add a 128x8 DDRAM behind data reads/writes; without it data reads return 0x00.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES      = 2000,
  parameter int BUSY_LONG_CYCLES = 76500,
  parameter int CNT_W            = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [3:0] LCD_D_in,
  output logic [3:0] LCD_D_out,
  output logic       LCD_D_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       cmd_rs,
  output logic       busy,
  output logic [6:0] addr,
  output logic       mode4bit,
  output logic       proto_err
);

  // state     | meaning
  // IDLE      | waiting for a qualified E rise
  // WR_STROBE | host write nibble in progress, data latched on E fall
  // RD_STROBE | host read nibble in progress, D driven until E fall
  typedef enum logic [1:0] {IDLE, WR_STROBE, RD_STROBE} state_t;

  state_t           r_state;
  logic [2:0]       r_e_s;
  logic [1:0]       r_rs_s, r_rw_s;
  logic [3:0]       r_d_s1, r_d_s2;
  logic             r_armed;
  logic [3:0]       r_d_out;
  logic             r_oe, r_cmd_valid, r_cmd_rs, r_perr;
  logic [7:0]       r_cmd_byte;
  logic [6:0]       r_ac;
  logic             r_mode4, r_phase_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_hi_nib;
  logic             r_hi_rs, r_hi_rw, r_stb_rs;

  logic       w_e, w_e_d, w_rise, w_fall, w_rs, w_rw, w_busy;
  logic [7:0] w_rd_data, w_byte;
  logic [3:0] w_rd_nib;
  logic       w_acc, w_mis, w_brs, w_rd_inc, w_is_home;

  // Synchronisers are deliberately not reset so a strobe held across RESET is still seen as high.
  always_ff @(posedge CLK) begin
    r_e_s  <= {r_e_s[1:0], LCD_E};
    r_rs_s <= {r_rs_s[0], LCD_RS};
    r_rw_s <= {r_rw_s[0], LCD_RW};
    r_d_s1 <= LCD_D_in;
    r_d_s2 <= r_d_s1;
  end

  assign w_e    = r_e_s[1];
  assign w_e_d  = r_e_s[2];
  assign w_rise = w_e & ~w_e_d & r_armed;
  assign w_fall = ~w_e & w_e_d;
  assign w_rs   = r_rs_s[1];
  assign w_rw   = r_rw_s[1];
  assign w_busy = (r_cnt != '0);

  always_comb begin
    w_rd_nib = {w_busy, r_ac[6:4]};
    if (r_mode4) begin
      if (w_rs)            w_rd_nib = r_phase_lo ? w_rd_data[3:0] : w_rd_data[7:4];
      else if (r_phase_lo) w_rd_nib = r_ac[3:0];
    end
  end

  always_comb begin
    w_acc  = 1'b0;
    w_mis  = 1'b0;
    w_byte = {r_d_s2, 4'h0};
    w_brs  = w_rs;
    if (w_fall && r_state == WR_STROBE) begin
      if (!r_mode4) begin
        w_acc = 1'b1;
      end else if (r_phase_lo) begin
        w_byte = {r_hi_nib, r_d_s2};
        if (w_rs != r_hi_rs || r_hi_rw) w_mis = 1'b1;
        else                            w_acc = 1'b1;
      end
    end
    if (w_fall && r_state == RD_STROBE && r_mode4 && r_phase_lo &&
        (r_stb_rs != r_hi_rs || !r_hi_rw))
      w_mis = 1'b1;
  end

  assign w_rd_inc  = w_fall && (r_state == RD_STROBE) && r_mode4 && r_phase_lo && !w_mis && r_stb_rs;
  assign w_is_home = (w_byte == 8'h01) || (w_byte[7:1] == 7'h01);

`ifdef LCD_RESPONDER_DDRAM_EN
  logic [7:0] r_ram [128];
  logic       r_clr_act;
  logic [6:0] r_clr_idx;

  assign w_rd_data = r_ram[r_ac];

  always_ff @(posedge CLK) begin
    if (r_clr_act)         r_ram[r_clr_idx] <= 8'h20;
    else if (w_acc && w_brs) r_ram[r_ac]    <= w_byte;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clr_act <= 1'b0;
      r_clr_idx <= '0;
    end else if (w_acc && !w_brs && w_byte == 8'h01) begin
      r_clr_act <= 1'b1;
      r_clr_idx <= '0;
    end else if (r_clr_act) begin
      r_clr_idx <= r_clr_idx + 7'd1;
      if (r_clr_idx == 7'h7F) r_clr_act <= 1'b0;
    end
  end
`else
  assign w_rd_data = 8'h00;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_d_out     <= '0;
      r_oe        <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= '0;
      r_cmd_rs    <= 1'b0;
      r_perr      <= 1'b0;
      r_ac        <= '0;
      r_mode4     <= 1'b0;
      r_phase_lo  <= 1'b0;
      r_cnt       <= '0;
      r_hi_nib    <= '0;
      r_hi_rs     <= 1'b0;
      r_hi_rw     <= 1'b0;
      r_stb_rs    <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_perr      <= w_mis;
      if (!w_e && !w_e_d) r_armed <= 1'b1;
      if (w_busy) r_cnt <= r_cnt - 1'b1;

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_stb_rs <= w_rs;
            if (w_rw) begin
              r_state <= RD_STROBE;
              r_oe    <= 1'b1;
              r_d_out <= w_rd_nib;
            end else begin
              r_state <= WR_STROBE;
            end
          end
        end
        WR_STROBE: begin
          if (w_fall) begin
            r_state <= IDLE;
            if (r_mode4) begin
              r_phase_lo <= ~r_phase_lo;
              if (!r_phase_lo) begin
                r_hi_nib <= r_d_s2;
                r_hi_rs  <= w_rs;
                r_hi_rw  <= 1'b0;
              end
            end
          end
        end
        RD_STROBE: begin
          if (w_fall) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
            if (r_mode4) begin
              r_phase_lo <= ~r_phase_lo;
              if (!r_phase_lo) begin
                r_hi_rs <= r_stb_rs;
                r_hi_rw <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_rd_inc) r_ac <= r_ac + 7'd1;

      // A write landing while busy is still decoded; the error pulse only flags the timing violation.
      if (w_acc) begin
        r_cmd_valid <= 1'b1;
        r_cmd_byte  <= w_byte;
        r_cmd_rs    <= w_brs;
        r_perr      <= w_busy;
        r_cnt       <= CNT_W'(BUSY_CYCLES);
        if (!w_brs) begin
          if (w_is_home) begin
            r_ac  <= '0;
            r_cnt <= CNT_W'(BUSY_LONG_CYCLES);
          end else if (w_byte[7]) begin
            r_ac <= w_byte[6:0];
          end else if (w_byte[7:5] == 3'b001) begin
            r_mode4 <= ~w_byte[4];
          end
        end else begin
          r_ac <= r_ac + 7'd1;
        end
      end
    end
  end

  assign LCD_D_out = r_d_out;
  assign LCD_D_oe  = r_oe;
  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign cmd_rs    = r_cmd_rs;
  assign busy      = w_busy;
  assign addr      = r_ac;
  assign mode4bit  = r_mode4;
  assign proto_err = r_perr;

endmodule
